core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Parametrised shared data-memory port for the multi-core processor.
- Arbitrates read and write requests from NUM_CORES cores onto one single-port synchronous data RAM (DRAM-style: write on clock edge, registered read).
- Round-robin fairness, one transaction in flight, per-core grant and read-valid handshake.
- Sits between the per-core AR/DR datapaths and the shared data memory.

Parameters:
- NUM_CORES, 4, number of requesting cores (>=1).
- DATA_W, 16, memory data width.
- ADDR_W, 16, memory address width.
- STAT_W, 16, width of each per-core grant counter (optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  NUM_CORES  per-core request; hold until own gnt seen.
- core_we  in  NUM_CORES  per-core 1=write, 0=read.
- core_addr  in  NUM_CORES*ADDR_W  flat addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  flat write data; same packing.
- core_gnt  out  NUM_CORES  one-hot grant pulse.
- core_rvalid  out  NUM_CORES  one-hot read-data-valid pulse.
- core_rdata  out  DATA_W  read data, broadcast; qualified by core_rvalid.
- mem_write_en  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_data_in  out  DATA_W  RAM write data.
- mem_data_out  in  DATA_W  RAM read data; valid one cycle after mem_addr is presented.
- busy  out  1  high whenever state != IDLE.
- grant_cnt  out  NUM_CORES*STAT_W  per-core grant counters; see Optional Feature.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer last = NUM_CORES-1 (core 0 highest priority first), latched registers 0.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - If any core_req is high, the winner is the first requester scanning last+1, last+2, ... modulo NUM_CORES.
  - Latch the winner's id, we, addr and wdata; set last = winner; go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (1 cycle):
  - core_gnt[id]=1, mem_addr=latched addr, mem_data_in=latched wdata, mem_write_en=latched we.
  - Write: return to IDLE. Read: go to RDWAIT.
- RDWAIT (1 cycle): mem_addr held, mem_write_en=0. At the edge, capture mem_data_out into core_rdata register; go to RESP.
- RESP (1 cycle): core_rvalid[id]=1, core_rdata valid; return to IDLE.
- Latency: gnt appears the cycle after req is seen in IDLE. rvalid appears 2 cycles after the gnt cycle.
- Throughput: write occupies 2 cycles (IDLE+ISSUE); read occupies 4 cycles.
- core_rdata holds its last value outside RESP.
- Requester rules:
  - Must hold req/we/addr/wdata stable until the gnt cycle.
  - Must drop req at the edge ending gnt unless immediately issuing a new transaction.
  - Requests seen outside IDLE are ignored and not queued; they are re-evaluated in the next IDLE.
- Mem outputs: mem_write_en is high only in ISSUE of a write. Outside ISSUE/RDWAIT, mem_addr and mem_data_in are 0.
- NUM_CORES=1: arbitration degenerates to always core 0. Id register width is max(1, clog2(NUM_CORES)).
- Reset mid-operation: outputs clear immediately (async). A pending write is not performed if rst_n falls before the ISSUE edge. A pending read never produces rvalid. The pointer returns to the reset value.
- Simultaneous req from all cores: exactly one grant per arbitration; other requesters keep holding.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - grant_cnt[i] increments by 1 on each grant to core i (IDLE->ISSUE edge).
  - Saturates at all-ones.
  - Cleared by reset.
- Undefined: grant_cnt is driven constant 0 and no counter flops exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset: rst_n low with random inputs -> all outputs 0, busy=0. Release -> IDLE, busy=0.
- Write then read:
  - Core 2 write addr 0x0010 data 0xBEEF -> gnt[2] one cycle; mem_write_en=1 for exactly that cycle with mem_addr 0x0010, mem_data_in 0xBEEF.
  - Then core 0 read 0x0010 -> rvalid[0] pulses 2 cycles after gnt[0], core_rdata=0xBEEF.
- All four cores request reads at once after reset, each holding until its gnt -> grant order 0,1,2,3; each rvalid matches its own id and address.
- Fairness: after core 1 is granted, cores 1 and 3 request writes continuously -> grant order 3,1,3,1; no back-to-back grants to the same core while the other waits.
- Reset mid-read: rst_n pulsed low during RDWAIT -> rvalid never asserts, busy drops immediately. Next simultaneous req from cores 0 and 3 -> core 0 granted.
- ARB_STATS_EN with STAT_W=2: 5 grants to core 2 -> grant_cnt core 2 = 3 (saturated), others 0. Without the macro, grant_cnt = 0 throughout.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// Core-side request/grant bus plus the shared data-RAM port of core_mem_arbiter.
// master = requesting cores + RAM model, slave = the arbiter.
interface core_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int STAT_W    = 16
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [NUM_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_write_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data_in;
    logic [DATA_W-1:0]           mem_data_out;
    logic                        busy;
    logic [NUM_CORES*STAT_W-1:0] grant_cnt;

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_data_out,
        input  core_gnt, core_rvalid, core_rdata, mem_write_en, mem_addr,
               mem_data_in, busy, grant_cnt
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_data_out,
        output core_gnt, core_rvalid, core_rdata, mem_write_en, mem_addr,
               mem_data_in, busy, grant_cnt
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter of NUM_CORES cores onto one single-port sync RAM; ARB_STATS_EN adds saturating grant counters.
// Latency: gnt 1 cycle after req seen in IDLE, rvalid 2 cycles after gnt; write = 2 cycles, read = 4 cycles.
// Backpressure: none queued; a core holds req until its gnt, requests outside IDLE wait for the next IDLE.
module core_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int STAT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    core_mem_arbiter_if.slave bus
);
    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [IDW-1:0]        last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_CORES-1:0]  gnt_q, gnt_d;
    logic [NUM_CORES-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_din_q, mem_din_d;

    logic [IDW-1:0]        win;
    logic                  win_vld;
    logic                  grant_now;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        int j;
        j       = 0;
        win     = last_q;
        win_vld = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            j = (int'(last_q) + k) % NUM_CORES;
            if (!win_vld && bus.core_req[j]) begin
                win     = IDW'(j);
                win_vld = 1'b1;
            end
        end
    end

    assign grant_now = (state_q == IDLE) && win_vld;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d       = win;
                    last_d     = win;
                    we_d       = bus.core_we[win];
                    addr_d     = bus.core_addr[int'(win)*ADDR_W +: ADDR_W];
                    gnt_d[win] = 1'b1;
                    mem_we_d   = bus.core_we[win];
                    mem_addr_d = bus.core_addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_din_d  = bus.core_wdata[int'(win)*DATA_W +: DATA_W];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = addr_q;
                    state_d    = RDWAIT;
                end
            end
            RDWAIT: begin
                // RAM output for the address issued last cycle is valid now.
                rdata_d        = bus.mem_data_out;
                rvalid_d[id_q] = 1'b1;
                state_d        = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            last_q     <= IDW'(NUM_CORES - 1);
            we_q       <= 1'b0;
            addr_q     <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.core_gnt     = gnt_q;
    assign bus.core_rvalid  = rvalid_q;
    assign bus.core_rdata   = rdata_q;
    assign bus.mem_write_en = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_din_q;
    assign bus.busy         = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_CORES];
    logic [STAT_W-1:0] cnt_d [NUM_CORES];

    always_comb begin
        cnt_d = cnt_q;
        if (grant_now && !(&cnt_q[win])) begin
            cnt_d[win] = cnt_q[win] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        assign bus.grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
    end
`else
    logic unused_grant;
    assign unused_grant  = grant_now;
    assign bus.grant_cnt = {NUM_CORES*STAT_W{1'b0}};
`endif
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: per-core request queues, a transaction-timeline model
// compared every cycle, and literal expectations on grant order, read data and counters.
`timescale 1ns/1ps
module tb_core_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
`ifdef ARB_STATS_EN
    localparam int SW = 2;
    localparam bit STATS = 1'b1;
`else
    localparam int SW = 16;
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    core_mem_arbiter_if #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .STAT_W(SW)) bus ();
    core_mem_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int unsigned cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Synchronous RAM: unwritten words read as addr ^ 16'hA5A5.
    logic [DW-1:0] ram [256];
    bit            ram_wr [256];
    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            ram[bus.mem_addr[7:0]]    <= bus.mem_data_in;
            ram_wr[bus.mem_addr[7:0]] <= 1'b1;
        end
        bus.mem_data_out <= ram_wr[bus.mem_addr[7:0]] ? ram[bus.mem_addr[7:0]]
                                                      : (DW'(bus.mem_addr[7:0]) ^ 16'hA5A5);
    end

    // Requesting cores.
    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
    txn_t cq [N][$];
    int unsigned gnt_cyc [N];
    int unsigned popped  [N];

    task automatic drive();
        if (!rst_n) begin
            bus.core_req   = N'($urandom);
            bus.core_we    = N'($urandom);
            bus.core_addr  = {$urandom, $urandom};
            bus.core_wdata = {$urandom, $urandom};
        end else begin
            for (int i = 0; i < N; i++) begin
                bus.core_req[i] = (cq[i].size() > 0);
                bus.core_we[i]  = (cq[i].size() > 0) ? cq[i][0].we : 1'b0;
                bus.core_addr[i*AW +: AW]  = (cq[i].size() > 0) ? cq[i][0].addr : '0;
                bus.core_wdata[i*DW +: DW] = (cq[i].size() > 0) ? cq[i][0].data : '0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin gnt_cyc[i] = 0; popped[i] = 0; end
        forever begin
            drive();
            @(posedge clk or rst_n);
            #1;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (gnt_cyc[i] != popped[i]) begin
                        popped[i] = gnt_cyc[i];
                        if (cq[i].size() > 0) void'(cq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic push(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        cq[c].push_back(t);
    endtask

    // Model: each accepted transaction schedules its visible effects on future cycles.
    bit [N-1:0]  e_gnt [8];
    bit [N-1:0]  e_rv  [8];
    bit          e_we  [8];
    bit [AW-1:0] e_addr[8];
    bit [DW-1:0] e_din [8];
    bit [DW-1:0] e_rd  [8];
    bit          e_busy[8];
    bit          e_rdw [8];
    int          ptr;
    int unsigned free_at;
    logic [DW-1:0] rdata_exp;
    int          cnt [N];
    bit [DW-1:0] mval [256];
    bit          mwr  [256];

    int gnt_log[$];
    int unsigned gnt_cyc_log[$];
    int rv_log[$];
    int unsigned rv_cyc_log[$];
    logic [DW-1:0] rv_dat_log[$];
    int we_cycles;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;

    function automatic logic [N*SW-1:0] exp_cnt();
        logic [N*SW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(cnt[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        int s, w, a8;
        cyc++;
        s = int'(cyc % 8);
        if (!rst_n) begin
            check("rst_gnt", bus.core_gnt, 0);
            check("rst_rvalid", bus.core_rvalid, 0);
            check("rst_rdata", bus.core_rdata, 0);
            check("rst_mem_we", bus.mem_write_en, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_mem_din", bus.mem_data_in, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_grant_cnt", bus.grant_cnt, 0);
            ptr = N - 1; free_at = 0; rdata_exp = '0;
            for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int i = 0; i < 8; i++) begin
                e_gnt[i] = 0; e_rv[i] = 0; e_we[i] = 0; e_addr[i] = 0;
                e_din[i] = 0; e_rd[i] = 0; e_busy[i] = 0; e_rdw[i] = 0;
            end
        end else begin
            if (e_rv[s] != 0) rdata_exp = e_rd[s];
            check("gnt", bus.core_gnt, e_gnt[s]);
            check("rvalid", bus.core_rvalid, e_rv[s]);
            check("rdata", bus.core_rdata, rdata_exp);
            check("mem_we", bus.mem_write_en, e_we[s]);
            check("mem_addr", bus.mem_addr, e_addr[s]);
            if (!e_rdw[s]) check("mem_din", bus.mem_data_in, e_din[s]);
            check("busy", bus.busy, e_busy[s]);
            check("grant_cnt", bus.grant_cnt, exp_cnt());
            e_gnt[s] = 0; e_rv[s] = 0; e_we[s] = 0; e_addr[s] = 0;
            e_din[s] = 0; e_rd[s] = 0; e_busy[s] = 0; e_rdw[s] = 0;
            if (cyc >= free_at && bus.core_req != 0) begin
                w = -1;
                for (int d = 1; d <= N; d++)
                    if (w < 0 && bus.core_req[(ptr + d) % N]) w = (ptr + d) % N;
                ptr = w;
                if (STATS && cnt[w] < (1 << SW) - 1) cnt[w]++;
                a8 = int'(bus.core_addr[w*AW +: 8]);
                s = int'((cyc + 1) % 8);
                e_gnt[s] = N'(1) << w;
                e_we[s] = bus.core_we[w];
                e_addr[s] = bus.core_addr[w*AW +: AW];
                e_din[s] = bus.core_wdata[w*DW +: DW];
                e_busy[s] = 1;
                if (bus.core_we[w]) begin
                    mval[a8] = bus.core_wdata[w*DW +: DW];
                    mwr[a8] = 1;
                    free_at = cyc + 2;
                end else begin
                    s = int'((cyc + 2) % 8);
                    e_addr[s] = bus.core_addr[w*AW +: AW];
                    e_busy[s] = 1; e_rdw[s] = 1;
                    s = int'((cyc + 3) % 8);
                    e_rv[s] = N'(1) << w;
                    e_rd[s] = mwr[a8] ? mval[a8] : (DW'(a8) ^ 16'hA5A5);
                    e_busy[s] = 1;
                    free_at = cyc + 4;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.core_gnt[i]) begin gnt_log.push_back(i); gnt_cyc_log.push_back(cyc); gnt_cyc[i] = cyc; end
            if (bus.core_rvalid[i]) begin rv_log.push_back(i); rv_cyc_log.push_back(cyc); rv_dat_log.push_back(bus.core_rdata); end
        end
        if (bus.mem_write_en) begin we_cycles++; wr_addr = bus.mem_addr; wr_dat = bus.mem_data_in; end
    end

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(queues_empty() && cyc >= free_at) && n < maxc);
        check("idle_within_budget", n < maxc, 1);
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc_log.delete(); rv_log.delete(); rv_cyc_log.delete(); rv_dat_log.delete();
        we_cycles = 0;
    endtask

    task automatic check_order(input string nm, input int exp_q[$]);
        check({nm, "_len"}, gnt_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(nm, (i < gnt_log.size()) ? gnt_log[i] : -1, exp_q[i]);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    initial begin
        int exp_o[$];
        int n;
        clear_logs();
        // Reset held with random inputs; per-cycle compare expects all-zero outputs.
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("busy_after_release", bus.busy, 0);
        check("gnt_after_release", bus.core_gnt, 0);

        // Write from core 2, then read it back on core 0.
        clear_logs();
        push(2, 1'b1, 16'h0010, 16'hBEEF);
        wait_idle(20);
        check("wr_cycles", we_cycles, 1);
        check("wr_addr", wr_addr, 16'h0010);
        check("wr_data", wr_dat, 16'hBEEF);
        push(0, 1'b0, 16'h0010, 16'h0000);
        wait_idle(20);
        exp_o = '{2, 0};
        check_order("wr_rd_order", exp_o);
        check("rd_rvalid_id", rv_log.size() > 0 ? rv_log[0] : -1, 0);
        check("rd_rdata", rv_dat_log.size() > 0 ? rv_dat_log[0] : 16'h0, 16'hBEEF);
        check("rd_latency", (rv_cyc_log.size() > 0 && gnt_cyc_log.size() > 1) ? rv_cyc_log[0] - gnt_cyc_log[1] : 0, 2);

        // All four cores read at once right after reset.
        pulse_reset();
        clear_logs();
        push(0, 1'b0, 16'h0020, 0); push(1, 1'b0, 16'h0021, 0);
        push(2, 1'b0, 16'h0022, 0); push(3, 1'b0, 16'h0023, 0);
        wait_idle(40);
        exp_o = '{0, 1, 2, 3};
        check_order("all_rd_order", exp_o);
        check("all_rd_cnt", rv_log.size(), 4);
        for (int i = 0; i < 4 && i < rv_log.size(); i++) check("all_rd_id", rv_log[i], i);
        if (rv_dat_log.size() == 4) begin
            check("all_rd_d0", rv_dat_log[0], 16'hA585);
            check("all_rd_d1", rv_dat_log[1], 16'hA584);
            check("all_rd_d2", rv_dat_log[2], 16'hA587);
            check("all_rd_d3", rv_dat_log[3], 16'hA586);
        end

        // Fairness between cores 1 and 3 after core 1 has just won.
        clear_logs();
        push(1, 1'b1, 16'h0040, 16'h1111);
        wait_idle(20);
        push(1, 1'b1, 16'h0041, 16'h2222); push(1, 1'b1, 16'h0042, 16'h3333);
        push(3, 1'b1, 16'h0043, 16'h4444); push(3, 1'b1, 16'h0044, 16'h5555);
        wait_idle(40);
        exp_o = '{1, 3, 1, 3, 1};
        check_order("fair_order", exp_o);

        // Reset during RDWAIT.
        clear_logs();
        push(2, 1'b0, 16'h0030, 0);
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin @(negedge clk); n++; end
        check("mid_rd_gnt_seen", gnt_log.size(), 1);
        @(posedge clk); #1;
        check("rdwait_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_rvalid", rv_log.size(), 0);
        push(0, 1'b1, 16'h0060, 16'h6060); push(3, 1'b1, 16'h0063, 16'h6363);
        wait_idle(20);
        exp_o = '{2, 0, 3};
        check_order("post_rst_order", exp_o);

        // Five grants to core 2 from a fresh reset.
        pulse_reset();
        clear_logs();
        for (int i = 0; i < 5; i++) push(2, 1'b1, AW'(16'h0050 + i), DW'(16'h7000 + i));
        wait_idle(40);
        check("stats_grants", gnt_log.size(), 5);
        check("stats_core2", bus.grant_cnt[2*SW +: SW], STATS ? 3 : 0);
        check("stats_core0", bus.grant_cnt[0*SW +: SW], 0);
        check("stats_core1", bus.grant_cnt[1*SW +: SW], 0);
        check("stats_core3", bus.grant_cnt[3*SW +: SW], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
